// File: rtl/uart_rx_packer.sv
// 8N1 UART receiver packing bytes little-endian into 32-bit words; word_valid one clk after the stop-bit sample or flush.
// Output register holds until word_ready; a hand-off while it is still occupied drops the new word and sets overrun.
module uart_rx_packer #(
   parameter int OVS = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        smp_tick,
   input  logic        rxd,
   input  logic        flush,
   output logic [31:0] word_data,
   output logic [2:0]  word_bytes,
   output logic        word_valid,
   input  logic        word_ready,
   output logic        frame_err,
   output logic        overrun,
   input  logic        err_clr
);

   localparam int TW = $clog2(OVS);
   localparam logic [TW-1:0] TICK_ONE  = 1;
   localparam logic [TW-1:0] TICK_HALF = TW'(OVS / 2 - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVS - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic          rxd_m;
   logic          rxd_s;
   logic [1:0]    state;
   logic [TW-1:0] tick_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift_reg;
   logic [31:0]   pack_data;
   logic [1:0]    pack_cnt;

   logic          stop_smp;
   logic          byte_done;
   logic          stop_err;
   logic [31:0]   merged;
   logic [2:0]    merged_cnt;
   logic          handoff;
   logic          out_free;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rxd_m <= 1'b1;
         rxd_s <= 1'b1;
      end else begin
         rxd_m <= rxd;
         rxd_s <= rxd_m;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         tick_cnt  <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
      end else if (!en) begin
         state    <= S_IDLE;
         tick_cnt <= '0;
         bit_cnt  <= '0;
      end else if (smp_tick) begin
         case (state)
            S_IDLE: begin
               tick_cnt <= '0;
               bit_cnt  <= '0;
               if (!rxd_s) state <= S_START;
            end
            S_START: begin
               // Decide at mid start bit: a glitch shorter than half a bit is a false start.
               if (tick_cnt == TICK_HALF) begin
                  tick_cnt <= '0;
                  bit_cnt  <= '0;
                  state    <= rxd_s ? S_IDLE : S_DATA;
               end else begin
                  tick_cnt <= tick_cnt + TICK_ONE;
               end
            end
            S_DATA: begin
               if (tick_cnt == TICK_LAST) begin
                  tick_cnt           <= '0;
                  shift_reg[bit_cnt] <= rxd_s;
                  bit_cnt            <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) state <= S_STOP;
               end else begin
                  tick_cnt <= tick_cnt + TICK_ONE;
               end
            end
            default: begin
               if (tick_cnt == TICK_LAST) begin
                  tick_cnt <= '0;
                  state    <= S_IDLE;
               end else begin
                  tick_cnt <= tick_cnt + TICK_ONE;
               end
            end
         endcase
      end
   end

   assign stop_smp  = en && smp_tick && (state == S_STOP) && (tick_cnt == TICK_LAST);
   assign byte_done = stop_smp && rxd_s;
   assign stop_err  = stop_smp && !rxd_s;
   assign out_free  = !word_valid || word_ready;

   // Pack the completing byte before evaluating flush so a coincident flush includes it.
   always_comb begin
      merged = pack_data;
      if (byte_done) begin
         case (pack_cnt)
            2'd0:    merged[7:0]   = shift_reg;
            2'd1:    merged[15:8]  = shift_reg;
            2'd2:    merged[23:16] = shift_reg;
            default: merged[31:24] = shift_reg;
         endcase
      end
      merged_cnt = {1'b0, pack_cnt} + {2'b00, byte_done};
      handoff    = en && ((merged_cnt == 3'd4) || (flush && (merged_cnt != 3'd0)));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pack_data <= '0;
         pack_cnt  <= '0;
      end else if (!en || handoff) begin
         pack_data <= '0;
         pack_cnt  <= '0;
      end else if (byte_done) begin
         pack_data <= merged;
         pack_cnt  <= merged_cnt[1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_data  <= '0;
         word_bytes <= '0;
         word_valid <= 1'b0;
      end else if (handoff && out_free) begin
         word_data  <= merged;
         word_bytes <= merged_cnt;
         word_valid <= 1'b1;
      end else if (word_valid && word_ready) begin
         word_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (stop_err)     frame_err <= 1'b1;
         else if (err_clr) frame_err <= 1'b0;
         if (handoff && !out_free) overrun <= 1'b1;
         else if (err_clr)         overrun <= 1'b0;
      end
   end

endmodule
